// File: rtl/rca_accum_ctrl.sv
// Sequencer that feeds an external ripple-carry adder to accumulate N_SAMPLES
// 16-bit samples into a 20-bit sum, holding operands SETTLE cycles per add.
module rca_accum_ctrl #(
  parameter int N_SAMPLES = 16,
  parameter int SETTLE    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic [15:0] add_a,
  output logic [19:0] add_b,
  output logic        add_cin,
  input  logic [19:0] add_s,
  output logic        busy,
  output logic        done,
  output logic [19:0] sum
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_IN, ADD, DONE} state_t;

  state_t        state;
  logic [15:0]   operand;
  logic [19:0]   acc;
  logic [4:0]    count;
  logic [SW-1:0] settle;

  assign add_a   = operand;
  assign add_b   = acc;
  assign add_cin = 1'b0;

  // add_s is only trusted on the last settle cycle; the ripple path is multicycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      operand  <= '0;
      acc      <= '0;
      count    <= '0;
      settle   <= '0;
      sum      <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            count    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= WAIT_IN;
          end
        end
        WAIT_IN: begin
          if (in_valid) begin
            operand  <= in_data;
            settle   <= '0;
            in_ready <= 1'b0;
            state    <= ADD;
          end
        end
        ADD: begin
          if (settle == SW'(SETTLE - 1)) begin
            acc   <= add_s;
            count <= count + 5'd1;
            if (count == 5'(N_SAMPLES - 1)) begin
              sum   <= add_s;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              in_ready <= 1'b1;
              state    <= WAIT_IN;
            end
          end else begin
            settle <= settle + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_accum_ctrl.sv
// Self-checking bench: default-parameter accumulator plus a N_SAMPLES=1,
// SETTLE=1 instance, each driving a behavioural adder and checked against a sum model.
module tb_rca_accum_ctrl;

  localparam int N = 16;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, in_valid;
  logic [15:0] in_data;
  logic        in_ready, add_cin, busy, done;
  logic [15:0] add_a;
  logic [19:0] add_b, add_s, sum;

  logic        start1, in_valid1;
  logic [15:0] in_data1;
  logic        in_ready1, add_cin1, busy1, done1;
  logic [15:0] add_a1;
  logic [19:0] add_b1, add_s1, sum1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // External adders modelled as plain combinational sums.
  assign add_s  = {4'd0, add_a}  + add_b  + {19'd0, add_cin};
  assign add_s1 = {4'd0, add_a1} + add_b1 + {19'd0, add_cin1};

  rca_accum_ctrl #(.N_SAMPLES(N), .SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s),
    .busy(busy), .done(done), .sum(sum)
  );

  rca_accum_ctrl #(.N_SAMPLES(1), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1), .add_s(add_s1),
    .busy(busy1), .done(done1), .sum(sum1)
  );

  // mode: 0 = all 0xFFFF, 1 = ramp 1..16, 2 = all 0x0001, 3 = random.
  task automatic run_dut(input int mode, input int max_gap, input bit pulse_start,
                         input int stop_after, output logic [19:0] obs_sum);
    logic [19:0] model_sum;
    logic [19:0] before_sum;
    logic [19:0] prev_sum;
    logic [15:0] cur_a;
    int accepted;
    int edges;
    int gap;
    int stalls;
    int done_cycle;
    bit seen_done;
    model_sum = '0;
    before_sum = '0;
    cur_a = '0;
    accepted = 0;
    edges = 0;
    stalls = 0;
    done_cycle = -1;
    seen_done = 1'b0;
    prev_sum = sum;
    obs_sum = sum;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
    for (int it = 0; it < 600; it++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen_done = 1'b1;
        done_cycle = edges;
        break;
      end
      if (stop_after > 0 && accepted == stop_after) break;
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL busy_during_run: got %b want 1 (edge %0d)", busy, edges);
      end
      checks++;
      if (sum !== prev_sum) begin
        failures++;
        $display("[TB] FAIL sum_held: got %h want %h (edge %0d)", sum, prev_sum, edges);
      end
      if (!in_ready && accepted > 0) begin
        checks++;
        if (add_a !== cur_a || add_b !== before_sum) begin
          failures++;
          $display("[TB] FAIL operands_stable: got a=%h b=%h want a=%h b=%h (edge %0d)",
                   add_a, add_b, cur_a, before_sum, edges);
        end
      end
      if (pulse_start && $urandom_range(3, 0) == 0) start = 1'b1;
      if (gap > 0) begin
        in_valid = 1'b0;
        gap--;
      end else begin
        in_valid = 1'b1;
        case (mode)
          0: in_data = 16'hFFFF;
          1: in_data = 16'(accepted + 1);
          2: in_data = 16'h0001;
          default: in_data = 16'($urandom);
        endcase
      end
      if (in_ready) begin
        if (in_valid) begin
          before_sum = model_sum;
          cur_a = in_data;
          model_sum = model_sum + {4'd0, in_data};
          accepted++;
          gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        end else begin
          stalls++;
        end
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (stop_after > 0) return;
    checks++;
    if (!seen_done) begin
      failures++;
      $display("[TB] FAIL done_timeout: got no done want done after %0d samples", N);
      return;
    end
    obs_sum = sum;
    checks++;
    if (accepted != N) begin
      failures++;
      $display("[TB] FAIL handshake_count: got %0d want %0d", accepted, N);
    end
    checks++;
    if (sum !== model_sum) begin
      failures++;
      $display("[TB] FAIL final_sum: got %h want %h", sum, model_sum);
    end
    checks++;
    if (done_cycle != N * (1 + S) + 1 + stalls) begin
      failures++;
      $display("[TB] FAIL done_cycle: got %0d want %0d", done_cycle, N * (1 + S) + 1 + stalls);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || sum !== model_sum) begin
      failures++;
      $display("[TB] FAIL after_done: got done=%b busy=%b rdy=%b sum=%h want 0 0 0 %h",
               done, busy, in_ready, sum, model_sum);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0; in_valid = 1'b0; in_data = '0;
    start1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, busy, done} !== 3'b000 || sum !== '0 || add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state: got rdy=%b busy=%b done=%b sum=%h a=%h b=%h cin=%b want all 0",
               in_ready, busy, done, sum, add_a, add_b, add_cin);
    end
    checks++;
    if ({in_ready1, busy1, done1} !== 3'b000 || sum1 !== '0) begin
      failures++;
      $display("[TB] FAIL reset_state_n1: got rdy=%b busy=%b done=%b sum=%h want all 0",
               in_ready1, busy1, done1, sum1);
    end
    rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({in_ready, busy, done} !== 3'b000) begin
        failures++;
        $display("[TB] FAIL idle_after_reset: got rdy=%b busy=%b done=%b want 000", in_ready, busy, done);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_single_settle;
    int edges;
    bit seen_done;
    edges = 0;
    seen_done = 1'b0;
    @(negedge clk);
    start1 = 1'b1;
    in_valid1 = 1'b1;
    in_data1 = 16'h1234;
    for (int it = 0; it < 20; it++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start1 = 1'b0;
      if (done1) begin
        seen_done = 1'b1;
        break;
      end
      if (busy1 && !in_ready1) begin
        checks++;
        if (add_a1 !== 16'h1234 || add_b1 !== 20'h0) begin
          failures++;
          $display("[TB] FAIL n1_operands_stable: got a=%h b=%h want a=1234 b=00000", add_a1, add_b1);
        end
      end
    end
    in_valid1 = 1'b0;
    checks++;
    if (!seen_done || edges != 3) begin
      failures++;
      $display("[TB] FAIL n1_done_cycle: got %0d (seen=%b) want 3", edges, seen_done);
    end
    checks++;
    if (sum1 !== 20'h01234) begin
      failures++;
      $display("[TB] FAIL n1_sum: got %h want 01234", sum1);
    end
  endtask

  task automatic test_full_scale;
    logic [19:0] s;
    run_dut(0, 0, 1'b0, 0, s);
    checks++;
    if (s !== 20'hFFFF0) begin
      failures++;
      $display("[TB] FAIL full_scale_sum: got %h want FFFF0", s);
    end
  endtask

  task automatic test_ramp_gaps;
    logic [19:0] s;
    run_dut(1, 3, 1'b0, 0, s);
    checks++;
    if (s !== 20'h00088) begin
      failures++;
      $display("[TB] FAIL ramp_sum: got %h want 00088", s);
    end
  endtask

  task automatic test_start_ignored;
    logic [19:0] s;
    run_dut(1, 1, 1'b1, 0, s);
    checks++;
    if (s !== 20'h00088) begin
      failures++;
      $display("[TB] FAIL start_ignored_sum: got %h want 00088", s);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [19:0] s;
    run_dut(0, 0, 1'b0, 5, s);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy, done} !== 3'b000 || sum !== '0 || add_b !== '0) begin
      failures++;
      $display("[TB] FAIL mid_reset_clear: got rdy=%b busy=%b done=%b sum=%h b=%h want all 0",
               in_ready, busy, done, sum, add_b);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || sum !== '0) begin
        failures++;
        $display("[TB] FAIL no_done_after_reset: got done=%b sum=%h want 0 00000", done, sum);
      end
    end
    run_dut(2, 0, 1'b0, 0, s);
    checks++;
    if (s !== 20'h00010) begin
      failures++;
      $display("[TB] FAIL rerun_sum: got %h want 00010", s);
    end
  endtask

  task automatic test_random;
    logic [19:0] s;
    repeat (3) run_dut(3, 2, 1'b1, 0, s);
  endtask

  initial begin
    test_reset();
    test_single_settle();
    test_full_scale();
    test_ramp_gaps();
    test_start_ignored();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
